ids_pkt_gen: RTL and testbench

- Packet-source stage that drives the same 64-bit data/ctrl/wr/rdy pipeline interface the IDS datapath modules receive on.
- Emits a burst of NetFPGA-format packets: one module-header word, then N payload words.
- An optional 64-bit pattern can be injected at a chosen payload word, so the downstream IDS match logic and its `matches` register can be exercised in simulation and on hardware.
- Sits upstream of the ids block, in place of the input arbiter, in test builds.

---
 rtl/ids_pkt_gen_pkg.sv | 32 +++
 rtl/ids_pkt_lfsr.sv | 32 +++
 rtl/ids_pkt_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_ids_pkt_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ids_pkt_gen_pkg.sv
// Shared constants, state encoding and header layout for the IDS packet generator.
// Also holds the LFSR seed, the LFSR tap mask and the LFSR step function.
package ids_pkt_gen_pkg;

    localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hFF;
    localparam logic [7:0]  LAST_WORD_CTRL     = 8'h01;
    localparam logic [7:0]  MID_WORD_CTRL      = 8'h00;

    // Galois form of x^64 + x^63 + x^61 + x^60 + 1, shifting right.
    localparam logic [63:0] LFSR_SEED = 64'h0000_0000_0000_0001;
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PAY  = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    typedef struct packed {
        logic [15:0] dst_port;
        logic [15:0] word_len;
        logic [15:0] rsvd;
        logic [15:0] byte_len;
    } hdr_t;

    function automatic logic [63:0] lfsr_step(input logic [63:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 64'h0);
    endfunction

endpackage

// File: rtl/ids_pkt_lfsr.sv
// 64-bit Galois LFSR that steps once per cycle with adv high.
// Latency: value reflects an advance on the following cycle; no backpressure of its own.
module ids_pkt_lfsr
    import ids_pkt_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        adv,
    output logic [63:0] value
);

    logic [63:0] lfsr_q;
    logic [63:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/ids_pkt_gen.sv
// Burst packet source: header word then N payload words, optional pattern injection; IDS_PKT_GEN_LFSR_EN selects LFSR payload.
// Latency: a word appears one cycle after the edge that sees out_rdy=1; out_rdy=0 stalls emission with state held.
module ids_pkt_gen
    import ids_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           cfg_num_pkts,
    input  logic [LEN_WIDTH-1:0]  cfg_len_words,
    input  logic [LEN_WIDTH-1:0]  cfg_pat_idx,
    input  logic [DATA_WIDTH-1:0] cfg_pattern,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [15:0]           cfg_dst_port,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           pkts_sent
);

    state_t                state_q,     state_d;
    logic [31:0]           num_pkts_q,  num_pkts_d;
    logic [LEN_WIDTH-1:0]  len_q,       len_d;
    logic [LEN_WIDTH-1:0]  pat_idx_q,   pat_idx_d;
    logic [LEN_WIDTH-1:0]  idx_q,       idx_d;
    logic [DATA_WIDTH-1:0] pattern_q,   pattern_d;
    logic [GAP_WIDTH-1:0]  gap_q,       gap_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q,   gap_cnt_d;
    logic [15:0]           dst_q,       dst_d;
    logic [31:0]           pkt_seq_q,   pkt_seq_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q,  out_ctrl_d;
    logic                  out_wr_q,    out_wr_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic [31:0]           pkts_sent_q, pkts_sent_d;

    hdr_t                  hdr_word;
    logic                  pat_hit;
    logic                  last_word;
    logic                  burst_end;
    logic [63:0]           fill_word;
    logic [DATA_WIDTH-1:0] pay_word;

    assign hdr_word.dst_port = dst_q;
    assign hdr_word.word_len = 16'(len_q);
    assign hdr_word.rsvd     = 16'h0;
    assign hdr_word.byte_len = 16'(len_q) << 3;

    // idx_q is 1-based and never exceeds len_q, so pat_idx 0 or beyond the length never hits.
    assign pat_hit   = (idx_q == pat_idx_q);
    assign last_word = (idx_q == len_q);
    assign burst_end = ((pkt_seq_q + 32'd1) == num_pkts_q) || stop_pend_q || stop;

`ifdef IDS_PKT_GEN_LFSR_EN
    logic [63:0] lfsr_val;
    logic        lfsr_adv;

    assign lfsr_adv  = (state_q == ST_PAY) && out_rdy && !pat_hit;
    assign fill_word = lfsr_val;

    ids_pkt_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (lfsr_adv),
        .value (lfsr_val)
    );
`else
    assign fill_word = {pkt_seq_q, 16'h0, 16'(idx_q)};
`endif

    assign pay_word = pat_hit ? pattern_q : DATA_WIDTH'(fill_word);

    always_comb begin
        state_d     = state_q;
        num_pkts_d  = num_pkts_q;
        len_d       = len_q;
        pat_idx_d   = pat_idx_q;
        idx_d       = idx_q;
        pattern_d   = pattern_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        dst_d       = dst_q;
        pkt_seq_d   = pkt_seq_q;
        stop_pend_d = stop_pend_q;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
        out_wr_d    = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pkts_sent_d = pkts_sent_q;

        // A stop seen anywhere in a burst is remembered until the packet boundary.
        if (stop && (state_q != ST_IDLE)) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_pkts_d  = cfg_num_pkts;
                    len_d       = (cfg_len_words == '0) ? LEN_WIDTH'(1) : cfg_len_words;
                    pat_idx_d   = cfg_pat_idx;
                    pattern_d   = cfg_pattern;
                    gap_d       = cfg_gap;
                    dst_d       = cfg_dst_port;
                    pkt_seq_d   = 32'd0;
                    stop_pend_d = 1'b0;
                    if (cfg_num_pkts == 32'd0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_HDR;
                        busy_d  = 1'b1;
                    end
                end
            end

            ST_HDR: begin
                if (out_rdy) begin
                    out_wr_d   = 1'b1;
                    out_data_d = DATA_WIDTH'(hdr_word);
                    out_ctrl_d = CTRL_WIDTH'(IO_QUEUE_STAGE_NUM);
                    idx_d      = LEN_WIDTH'(1);
                    state_d    = ST_PAY;
                end
            end

            ST_PAY: begin
                if (out_rdy) begin
                    out_wr_d   = 1'b1;
                    out_data_d = pay_word;
                    if (last_word) begin
                        out_ctrl_d  = CTRL_WIDTH'(LAST_WORD_CTRL);
                        pkts_sent_d = pkts_sent_q + 32'd1;
                        pkt_seq_d   = pkt_seq_q + 32'd1;
                        if (burst_end) begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else if (gap_q == '0) begin
                            state_d = ST_HDR;
                        end else begin
                            gap_cnt_d = gap_q;
                            state_d   = ST_GAP;
                        end
                    end else begin
                        out_ctrl_d = CTRL_WIDTH'(MID_WORD_CTRL);
                        idx_d      = idx_q + LEN_WIDTH'(1);
                    end
                end
            end

            ST_GAP: begin
                if (stop || stop_pend_q) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    state_d = ST_HDR;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_pkts_q  <= '0;
            len_q       <= '0;
            pat_idx_q   <= '0;
            idx_q       <= '0;
            pattern_q   <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            dst_q       <= '0;
            pkt_seq_q   <= '0;
            stop_pend_q <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            out_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pkts_sent_q <= '0;
        end else begin
            state_q     <= state_d;
            num_pkts_q  <= num_pkts_d;
            len_q       <= len_d;
            pat_idx_q   <= pat_idx_d;
            idx_q       <= idx_d;
            pattern_q   <= pattern_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            dst_q       <= dst_d;
            pkt_seq_q   <= pkt_seq_d;
            stop_pend_q <= stop_pend_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            out_wr_q    <= out_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pkts_sent_q <= pkts_sent_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_wr    = out_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pkts_sent = pkts_sent_q;

endmodule

// File: tb/tb_ids_pkt_gen.sv
// Directed bench for ids_pkt_gen in its default (deterministic filler) build.
module tb_ids_pkt_gen;

    logic        clk = 1'b0;
    logic        reset, start, stop, out_rdy;
    logic [31:0] cfg_num_pkts;
    logic [7:0]  cfg_len_words, cfg_pat_idx, cfg_gap;
    logic [63:0] cfg_pattern;
    logic [15:0] cfg_dst_port;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr, busy, done;
    logic [31:0] pkts_sent;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] wq_data[$];
    logic [7:0]  wq_ctrl[$];
    int          nordy_wr = 0;
    int          done_cnt = 0;
    logic        rdy_at_edge;

    always #5 clk = ~clk;

    ids_pkt_gen dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .cfg_num_pkts  (cfg_num_pkts),
        .cfg_len_words (cfg_len_words),
        .cfg_pat_idx   (cfg_pat_idx),
        .cfg_pattern   (cfg_pattern),
        .cfg_gap       (cfg_gap),
        .cfg_dst_port  (cfg_dst_port),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .out_wr        (out_wr),
        .out_rdy       (out_rdy),
        .busy          (busy),
        .done          (done),
        .pkts_sent     (pkts_sent)
    );

    // Output monitor: captures every emitted word and flags a write that follows out_rdy=0.
    always @(posedge clk) begin
        rdy_at_edge = out_rdy;
        #2;
        if (out_wr === 1'b1) begin
            wq_data.push_back(out_data);
            wq_ctrl.push_back(out_ctrl);
            if (rdy_at_edge !== 1'b1) nordy_wr++;
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    function automatic logic [63:0] exp_hdr(input logic [15:0] dst, input logic [15:0] len);
        return {dst, len, 16'h0, len * 16'd8};
    endfunction

    function automatic logic [63:0] exp_fill(input logic [31:0] seq, input logic [15:0] idx);
        return {seq, 16'h0, idx};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic clear_mon;
        wq_data.delete();
        wq_ctrl.delete();
        nordy_wr = 0;
        done_cnt = 0;
    endtask

    task automatic apply_reset;
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        out_rdy = 1'b1;
        cyc(2);
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic set_cfg(input logic [31:0] n, input logic [7:0] len, input logic [7:0] pidx,
                           input logic [63:0] pat, input logic [7:0] gap, input logic [15:0] dst);
        cfg_num_pkts  = n;
        cfg_len_words = len;
        cfg_pat_idx   = pidx;
        cfg_pattern   = pat;
        cfg_gap       = gap;
        cfg_dst_port  = dst;
    endtask

    task automatic kick;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!seen) $display("FAIL %s: done pulses seen 0 within %0d cycles, required 1", name, budget);
        else n_pass++;
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (wq_data.size() >= n) begin
                seen = 1'b1;
                break;
            end
            cyc(1);
        end
        n_chk++;
        if (!seen) $display("FAIL %s: words seen %0d, required %0d", name, wq_data.size(), n);
        else n_pass++;
    endtask

    task automatic test_reset;
        apply_reset();
        n_chk++;
        if ({out_wr, busy, done} !== 3'b000) $display("FAIL reset_flags: wr/busy/done %b, required 000", {out_wr, busy, done});
        else n_pass++;
        n_chk++;
        if (out_data !== 64'h0 || out_ctrl !== 8'h0) $display("FAIL reset_data: data %h ctrl %h, required 0 0", out_data, out_ctrl);
        else n_pass++;
        n_chk++;
        if (pkts_sent !== 32'h0) $display("FAIL reset_pkts_sent: got %0d, required 0", pkts_sent);
        else n_pass++;
    endtask

    task automatic test_single;
        logic [63:0] ed[4];
        logic [7:0]  ec[4];
        ed = '{64'h0004_0003_0000_0018, 64'h0000_0000_0000_0001, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0003};
        ec = '{8'hFF, 8'h00, 8'h00, 8'h01};
        apply_reset();
        set_cfg(32'd1, 8'd3, 8'd2, 64'h0123_4567_89AB_CDEF, 8'd0, 16'h0004);
        kick();
        wait_done(50, "single_done");
        n_chk++;
        if (pkts_sent !== 32'd1) $display("FAIL single_pkts_sent: got %0d, required 1", pkts_sent);
        else n_pass++;
        cyc(3);
        n_chk++;
        if (wq_data.size() !== 4) $display("FAIL single_count: got %0d words, required 4", wq_data.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < wq_data.size(); i++) begin
            n_chk++;
            if (wq_data[i] !== ed[i] || wq_ctrl[i] !== ec[i])
                $display("FAIL single_word%0d: got %h/%h, required %h/%h", i, wq_data[i], wq_ctrl[i], ed[i], ec[i]);
            else n_pass++;
        end
        n_chk++;
        if (done_cnt !== 1 || busy !== 1'b0) $display("FAIL single_done_once: pulses %0d busy %b, required 1 0", done_cnt, busy);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        bit seen = 1'b0;
        logic [63:0] ed[10];
        apply_reset();
        set_cfg(32'd2, 8'd4, 8'd0, 64'h0, 8'd1, 16'h0001);
        for (int p = 0; p < 2; p++) begin
            ed[p*5] = exp_hdr(16'h0001, 16'd4);
            for (int w = 1; w <= 4; w++) ed[p*5+w] = exp_fill(32'(p), 16'(w));
        end
        kick();
        for (int i = 0; i < 300; i++) begin
            out_rdy = ((i % 4) == 0) || ((i % 4) == 3);
            cyc(1);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        out_rdy = 1'b1;
        n_chk++;
        if (!seen) $display("FAIL bp_done: done not seen within 300 cycles, required 1 pulse");
        else n_pass++;
        cyc(2);
        n_chk++;
        if (wq_data.size() !== 10) $display("FAIL bp_count: got %0d words, required 10", wq_data.size());
        else n_pass++;
        for (int i = 0; i < 10 && i < wq_data.size(); i++) begin
            n_chk++;
            if (wq_data[i] !== ed[i]) $display("FAIL bp_word%0d: got %h, required %h", i, wq_data[i], ed[i]);
            else n_pass++;
        end
        n_chk++;
        if (nordy_wr !== 0) $display("FAIL bp_wr_after_nordy: got %0d writes, required 0", nordy_wr);
        else n_pass++;
        n_chk++;
        if (pkts_sent !== 32'd2) $display("FAIL bp_pkts_sent: got %0d, required 2", pkts_sent);
        else n_pass++;
    endtask

    task automatic test_gap;
        bit in_gap = 1'b0;
        bit seen   = 1'b0;
        int run    = 0;
        int gaps   = 0;
        apply_reset();
        set_cfg(32'd3, 8'd2, 8'd0, 64'h0, 8'd5, 16'h0002);
        kick();
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (out_wr === 1'b1 && out_ctrl === 8'hFF && in_gap) begin
                n_chk++;
                if (run < 5) $display("FAIL gap_idle%0d: got %0d idle cycles, required >= 5", gaps, run);
                else n_pass++;
                gaps++;
                in_gap = 1'b0;
            end else if (out_wr === 1'b1 && out_ctrl === 8'h01) begin
                in_gap = 1'b1;
                run    = 0;
            end else if (out_wr === 1'b0 && in_gap) begin
                run++;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!seen || gaps !== 2) $display("FAIL gap_count: done %0d gaps %0d, required 1 2", seen, gaps);
        else n_pass++;
        n_chk++;
        if (pkts_sent !== 32'd3 || wq_data.size() !== 9) $display("FAIL gap_totals: pkts %0d words %0d, required 3 9", pkts_sent, wq_data.size());
        else n_pass++;
    endtask

    task automatic test_boundaries;
        apply_reset();
        set_cfg(32'd0, 8'd3, 8'd0, 64'h0, 8'd0, 16'h0001);
        kick();
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_pkts_done: done %b busy %b, required 1 0", done, busy);
        else n_pass++;
        cyc(3);
        n_chk++;
        if (wq_data.size() !== 0 || done_cnt !== 1) $display("FAIL zero_pkts_quiet: words %0d pulses %0d, required 0 1", wq_data.size(), done_cnt);
        else n_pass++;

        clear_mon();
        set_cfg(32'd1, 8'd0, 8'd0, 64'h0, 8'd0, 16'h0002);
        kick();
        wait_done(50, "len0_done");
        cyc(2);
        n_chk++;
        if (wq_data.size() !== 2) $display("FAIL len0_count: got %0d words, required 2", wq_data.size());
        else n_pass++;
        if (wq_data.size() == 2) begin
            n_chk++;
            if (wq_data[0] !== 64'h0002_0001_0000_0008) $display("FAIL len0_hdr: got %h, required %h", wq_data[0], 64'h0002_0001_0000_0008);
            else n_pass++;
            n_chk++;
            if (wq_data[1] !== 64'h1 || wq_ctrl[1] !== 8'h01) $display("FAIL len0_pay: got %h/%h, required %h/01", wq_data[1], wq_ctrl[1], 64'h1);
            else n_pass++;
        end

        clear_mon();
        set_cfg(32'd1, 8'd4, 8'd9, 64'hDEAD_BEEF_CAFE_F00D, 8'd0, 16'h0008);
        kick();
        wait_done(50, "patidx_done");
        cyc(2);
        n_chk++;
        if (wq_data.size() !== 5) $display("FAIL patidx_count: got %0d words, required 5", wq_data.size());
        else n_pass++;
        for (int i = 1; i < 5 && i < wq_data.size(); i++) begin
            n_chk++;
            if (wq_data[i] !== exp_fill(32'd0, 16'(i))) $display("FAIL patidx_word%0d: got %h, required %h", i, wq_data[i], exp_fill(32'd0, 16'(i)));
            else n_pass++;
        end
    endtask

    task automatic test_stop_start;
        apply_reset();
        set_cfg(32'd10, 8'd3, 8'd0, 64'h0, 8'd2, 16'h0008);
        kick();
        wait_words(1, 20, "stop_first_hdr");
        set_cfg(32'd1, 8'd7, 8'd0, 64'h0, 8'd0, 16'h0001);
        kick();
        wait_words(5, 40, "stop_second_hdr");
        stop = 1'b1;
        wait_done(100, "stop_done");
        stop = 1'b0;
        cyc(3);
        n_chk++;
        if (pkts_sent !== 32'd2) $display("FAIL stop_pkts_sent: got %0d, required 2", pkts_sent);
        else n_pass++;
        n_chk++;
        if (wq_data.size() !== 8 || done_cnt !== 1) $display("FAIL stop_count: words %0d pulses %0d, required 8 1", wq_data.size(), done_cnt);
        else n_pass++;
        if (wq_data.size() == 8) begin
            n_chk++;
            if (wq_data[4] !== exp_hdr(16'h0008, 16'd3)) $display("FAIL busy_start_ignored: got %h, required %h", wq_data[4], exp_hdr(16'h0008, 16'd3));
            else n_pass++;
            n_chk++;
            if (wq_data[7] !== exp_fill(32'd1, 16'd3) || wq_ctrl[7] !== 8'h01) $display("FAIL stop_last_word: got %h/%h, required %h/01", wq_data[7], wq_ctrl[7], exp_fill(32'd1, 16'd3));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        set_cfg(32'd5, 8'd2, 8'd0, 64'h0, 8'd0, 16'h0001);
        kick();
        wait_words(5, 40, "rst_mid_progress");
        reset = 1'b1;
        cyc(1);
        n_chk++;
        if ({out_wr, busy, done} !== 3'b000 || out_data !== 64'h0 || out_ctrl !== 8'h0)
            $display("FAIL rst_mid_outputs: wr/busy/done %b data %h ctrl %h, required 000 0 0", {out_wr, busy, done}, out_data, out_ctrl);
        else n_pass++;
        n_chk++;
        if (pkts_sent !== 32'd0) $display("FAIL rst_mid_pkts_sent: got %0d, required 0", pkts_sent);
        else n_pass++;
        reset = 1'b0;
        clear_mon();
        set_cfg(32'd1, 8'd2, 8'd0, 64'h0, 8'd0, 16'h0001);
        kick();
        wait_done(50, "rst_restart_done");
        cyc(2);
        n_chk++;
        if (wq_data.size() !== 3) $display("FAIL rst_restart_count: got %0d words, required 3", wq_data.size());
        else n_pass++;
        if (wq_data.size() == 3) begin
            n_chk++;
            if (wq_data[1] !== 64'h0000_0000_0000_0001) $display("FAIL rst_restart_seq: got %h, required %h", wq_data[1], 64'h1);
            else n_pass++;
        end
        n_chk++;
        if (pkts_sent !== 32'd1) $display("FAIL rst_restart_pkts_sent: got %0d, required 1", pkts_sent);
        else n_pass++;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        out_rdy = 1'b1;
        set_cfg(32'd0, 8'd0, 8'd0, 64'h0, 8'd0, 16'h0);
        test_reset();
        test_single();
        test_backpressure();
        test_gap();
        test_boundaries();
        test_stop_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
